// File: rtl/pipeline_pkg.sv
// Types shared by the decode and execute stages of the RV32I pipeline.
package pipeline_pkg;

  // ALU operation codes; the ALU decoder produces these same encodings.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  // Operand forward select driven by the hazard unit (2'b11 falls back to the register value).
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Decode control word, MSB first in the same order as the i_ctrl_d bus.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational integer ALU of the execute stage.
module alu
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [2:0]      alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // Select the operation; unassigned codes produce zero.
  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch decision, EX/MEM register.
module ex_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush_e,
  input  logic              i_stall_e,
  input  logic              i_valid_d,
  input  logic [CTRL_W-1:0] i_ctrl_d,
  input  logic [XLEN-1:0]   i_rd1_d,
  input  logic [XLEN-1:0]   i_rd2_d,
  input  logic [XLEN-1:0]   i_imm_d,
  input  logic [XLEN-1:0]   i_pc_d,
  input  logic [XLEN-1:0]   i_pcplus4_d,
  input  logic [REG_AW-1:0] i_rs1_d,
  input  logic [REG_AW-1:0] i_rs2_d,
  input  logic [REG_AW-1:0] i_rd_d,
  input  logic [1:0]        i_fwd_a_e,
  input  logic [1:0]        i_fwd_b_e,
  input  logic [XLEN-1:0]   i_alures_m,
  input  logic [XLEN-1:0]   i_result_w,
  output logic [REG_AW-1:0] o_rs1_e,
  output logic [REG_AW-1:0] o_rs2_e,
  output logic [REG_AW-1:0] o_rd_e,
  output logic              o_resultsrc0_e,
  output logic              o_pcsrc_e,
  output logic [XLEN-1:0]   o_pctarget_e,
  output logic              o_valid_m,
  output logic              o_regwrite_m,
  output logic              o_memwrite_m,
  output logic [1:0]        o_resultsrc_m,
  output logic [XLEN-1:0]   o_alures_m,
  output logic [XLEN-1:0]   o_writedata_m,
  output logic [XLEN-1:0]   o_pcplus4_m,
  output logic [REG_AW-1:0] o_rd_m
);

  logic              valid_e;
  ctrl_t             ctrl_e;
  logic [XLEN-1:0]   rd1_e, rd2_e, imm_e, pc_e, pcplus4_e;
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;

  logic [XLEN-1:0]   src_a, fwd_b, src_b, alu_res;
  logic              zero;

  // ID/EX register: flush beats stall; a flush clears the whole slot, not just the control bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || i_flush_e) begin
      valid_e   <= 1'b0;
      ctrl_e    <= '0;
      rd1_e     <= '0;
      rd2_e     <= '0;
      imm_e     <= '0;
      pc_e      <= '0;
      pcplus4_e <= '0;
      rs1_e     <= '0;
      rs2_e     <= '0;
      rd_e      <= '0;
    end else if (!i_stall_e) begin
      valid_e   <= i_valid_d;
      ctrl_e    <= ctrl_t'(i_ctrl_d);
      rd1_e     <= i_rd1_d;
      rd2_e     <= i_rd2_d;
      imm_e     <= i_imm_d;
      pc_e      <= i_pc_d;
      pcplus4_e <= i_pcplus4_d;
      rs1_e     <= i_rs1_d;
      rs2_e     <= i_rs2_d;
      rd_e      <= i_rd_d;
    end
  end

  // Forwarding muxes; select 2'b11 falls through to the register value.
  always_comb begin
    src_a = rd1_e;
    fwd_b = rd2_e;
    case (fwd_sel_e'(i_fwd_a_e))
      FWD_WB:  src_a = i_result_w;
      FWD_MEM: src_a = i_alures_m;
      default: src_a = rd1_e;
    endcase
    case (fwd_sel_e'(i_fwd_b_e))
      FWD_WB:  fwd_b = i_result_w;
      FWD_MEM: fwd_b = i_alures_m;
      default: fwd_b = rd2_e;
    endcase
    src_b = ctrl_e.alu_src ? imm_e : fwd_b;
  end

  alu #(.XLEN(XLEN)) u_alu (
    .src_a    (src_a),
    .src_b    (src_b),
    .alu_ctrl (ctrl_e.alu_ctrl),
    .result   (alu_res),
    .zero     (zero)
  );

  assign o_rs1_e        = rs1_e;
  assign o_rs2_e        = rs2_e;
  assign o_rd_e         = rd_e;
  assign o_resultsrc0_e = ctrl_e.result_src[0];
  assign o_pcsrc_e      = valid_e & (ctrl_e.jump | (ctrl_e.branch & zero));
  assign o_pctarget_e   = pc_e + imm_e;

  // EX/MEM register: advances every cycle, so a stalled valid E slot is copied on each edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_m     <= 1'b0;
      o_regwrite_m  <= 1'b0;
      o_memwrite_m  <= 1'b0;
      o_resultsrc_m <= '0;
      o_alures_m    <= '0;
      o_writedata_m <= '0;
      o_pcplus4_m   <= '0;
      o_rd_m        <= '0;
    end else begin
      o_valid_m     <= valid_e;
      o_regwrite_m  <= ctrl_e.reg_write;
      o_memwrite_m  <= ctrl_e.mem_write;
      o_resultsrc_m <= ctrl_e.result_src;
      o_alures_m    <= alu_res;
      o_writedata_m <= fwd_b;
      o_pcplus4_m   <= pcplus4_e;
      o_rd_m        <= rd_e;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, corner sequences, random stream vs model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, stall;
  logic        valid_d;
  logic [9:0]  ctrl_d;
  logic [31:0] rd1_d, rd2_d, imm_d, pc_d, pc4_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] am, rw;

  logic [4:0]  rs1_e, rs2_e, rd_e, rd_m;
  logic        rsrc0_e, pcsrc_e, valid_m, regwrite_m, memwrite_m;
  logic [31:0] tgt_e, alures_m, wdata_m, pc4_m;
  logic [1:0]  rsrc_m;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush_e(flush), .i_stall_e(stall),
    .i_valid_d(valid_d), .i_ctrl_d(ctrl_d),
    .i_rd1_d(rd1_d), .i_rd2_d(rd2_d), .i_imm_d(imm_d), .i_pc_d(pc_d), .i_pcplus4_d(pc4_d),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rd_d(rd_d),
    .i_fwd_a_e(fwd_a), .i_fwd_b_e(fwd_b), .i_alures_m(am), .i_result_w(rw),
    .o_rs1_e(rs1_e), .o_rs2_e(rs2_e), .o_rd_e(rd_e), .o_resultsrc0_e(rsrc0_e),
    .o_pcsrc_e(pcsrc_e), .o_pctarget_e(tgt_e),
    .o_valid_m(valid_m), .o_regwrite_m(regwrite_m), .o_memwrite_m(memwrite_m),
    .o_resultsrc_m(rsrc_m), .o_alures_m(alures_m), .o_writedata_m(wdata_m),
    .o_pcplus4_m(pc4_m), .o_rd_m(rd_m)
  );

  // Instruction as seen by the model; ctrl bits: 9 RegWrite, 8:7 ResultSrc, 6 MemWrite, 5 Jump, 4 Branch, 3 ALUSrc, 2:0 ALU op.
  typedef struct {
    bit          valid;
    logic [9:0]  ctrl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } instr_t;

  typedef struct {
    bit          valid, regw, memw;
    logic [1:0]  rsrc;
    logic [31:0] res, wd, pc4;
    logic [4:0]  rd;
  } mrec_t;

  typedef struct {
    bit          valid;
    logic [9:0]  ctrl;
    logic [31:0] rd1, rd2, imm, pc;
    logic [1:0]  fa, fb;
    logic [31:0] am, rw;
    logic [31:0] exp_res, exp_wd, exp_tgt;
    bit          exp_pcsrc;
  } vec_t;

  function automatic logic [9:0] mk_ctrl(input bit regw, input int rsrc, input bit memw,
                                         input bit jmp, input bit br, input bit asrc, input int op);
    logic [1:0] r2;
    logic [2:0] o3;
    r2 = rsrc[1:0];
    o3 = op[2:0];
    return {regw, r2, memw, jmp, br, asrc, o3};
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return regv;
  endfunction

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic mrec_t exec(input instr_t s, input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [31:0] mem, input logic [31:0] wb);
    mrec_t m;
    logic [31:0] a, bf, b;
    a  = pick(fa, s.rd1, wb, mem);
    bf = pick(fb, s.rd2, wb, mem);
    b  = s.ctrl[3] ? s.imm : bf;
    m.valid = s.valid;
    m.regw  = s.ctrl[9];
    m.memw  = s.ctrl[6];
    m.rsrc  = s.ctrl[8:7];
    m.res   = ref_alu(int'(s.ctrl[2:0]), a, b);
    m.wd    = bf;
    m.pc4   = s.pc4;
    m.rd    = s.rd;
    return m;
  endfunction

  function automatic bit ref_pcsrc(input instr_t s, input mrec_t m);
    return s.valid && (s.ctrl[5] || (s.ctrl[4] && m.res == 32'd0));
  endfunction

  function automatic instr_t snap_d();
    instr_t s;
    s.valid = valid_d; s.ctrl = ctrl_d;
    s.rd1 = rd1_d; s.rd2 = rd2_d; s.imm = imm_d; s.pc = pc_d; s.pc4 = pc4_d;
    s.rs1 = rs1_d; s.rs2 = rs2_d; s.rd = rd_d;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pcsrc"},   32'(pcsrc_e), 32'd0);
    chk({tag, " target"},  tgt_e, 32'd0);
    chk({tag, " e_idx"},   {17'd0, rs1_e, rs2_e, rd_e}, 32'd0);
    chk({tag, " rsrc0_e"}, 32'(rsrc0_e), 32'd0);
    chk({tag, " m_ctrl"},  {27'd0, valid_m, regwrite_m, memwrite_m, rsrc_m}, 32'd0);
    chk({tag, " alures"},  alures_m, 32'd0);
    chk({tag, " wdata"},   wdata_m, 32'd0);
    chk({tag, " pc4_m"},   pc4_m, 32'd0);
    chk({tag, " rd_m"},    32'(rd_m), 32'd0);
  endtask

  task automatic idle_d();
    valid_d = 1'b0; ctrl_d = '0;
    rd1_d = '0; rd2_d = '0; imm_d = '0; pc_d = '0; pc4_d = '0;
    rs1_d = '0; rs2_d = '0; rd_d = '0;
  endtask

  vec_t vt[15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t e, d;
    mrec_t  mexp, cur;

    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    fwd_a = 2'd0; fwd_b = 2'd0; am = '0; rw = '0;
    idle_d();

    //              valid ctrl                        rd1           rd2           imm           pc          fa fb am      rw     res           wd            tgt          pcsrc
    vt[0]  = '{1'b1, mk_ctrl(1,0,0,0,0,0,0), 32'd5,        32'd7,        32'd0,        32'd0,      0, 0, 32'd0,  32'd0, 32'd12,       32'd7,        32'd0,       1'b0};
    vt[1]  = '{1'b1, mk_ctrl(1,0,0,0,0,0,5), 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,      0, 0, 32'd0,  32'd0, 32'd1,        32'd1,        32'd0,       1'b0};
    vt[2]  = '{1'b1, mk_ctrl(1,0,0,0,0,0,1), 32'd0,        32'd1,        32'd0,        32'd0,      0, 0, 32'd0,  32'd0, 32'hFFFFFFFF, 32'd1,        32'd0,       1'b0};
    vt[3]  = '{1'b1, mk_ctrl(1,0,0,0,0,0,1), 32'd555,      32'd666,      32'd0,        32'd0,      2, 1, 32'd100,32'd20,32'd80,       32'd20,       32'd0,       1'b0};
    vt[4]  = '{1'b1, mk_ctrl(1,0,0,0,0,0,0), 32'd30,       32'd12,       32'd0,        32'd0,      3, 3, 32'd1,  32'd2, 32'd42,       32'd12,       32'd0,       1'b0};
    vt[5]  = '{1'b1, mk_ctrl(0,0,0,0,1,0,1), 32'd9,        32'd9,        32'h10,       32'h40,     0, 0, 32'd0,  32'd0, 32'd0,        32'd9,        32'h50,      1'b1};
    vt[6]  = '{1'b0, mk_ctrl(0,0,0,0,1,0,1), 32'd9,        32'd9,        32'h10,       32'h40,     0, 0, 32'd0,  32'd0, 32'd0,        32'd9,        32'h50,      1'b0};
    vt[7]  = '{1'b1, mk_ctrl(1,0,0,0,0,0,2), 32'hF0F0,     32'hFF00,     32'd0,        32'd0,      0, 0, 32'd0,  32'd0, 32'hF000,     32'hFF00,     32'd0,       1'b0};
    vt[8]  = '{1'b1, mk_ctrl(1,0,0,0,0,0,3), 32'hF0F0,     32'h0F0F,     32'd0,        32'd0,      0, 0, 32'd0,  32'd0, 32'hFFFF,     32'h0F0F,     32'd0,       1'b0};
    vt[9]  = '{1'b1, mk_ctrl(1,0,0,0,0,1,0), 32'd100,      32'd77,       32'hFFFFFFFC, 32'h1000,   0, 0, 32'd0,  32'd0, 32'd96,       32'd77,       32'hFFC,     1'b0};
    vt[10] = '{1'b1, mk_ctrl(1,2,0,1,0,0,7), 32'd3,        32'd4,        32'd8,        32'h20,     0, 0, 32'd0,  32'd0, 32'd0,        32'd4,        32'h28,      1'b1};
    vt[11] = '{1'b1, mk_ctrl(0,0,0,0,1,0,1), 32'd1,        32'd2,        32'h100,      32'h200,    0, 0, 32'd0,  32'd0, 32'hFFFFFFFF, 32'd2,        32'h300,     1'b0};
    vt[12] = '{1'b1, mk_ctrl(1,1,1,0,0,0,5), 32'd5,        32'hFFFFFFFF, 32'd0,        32'd0,      0, 0, 32'd0,  32'd0, 32'd0,        32'hFFFFFFFF, 32'd0,       1'b0};
    vt[13] = '{1'b1, mk_ctrl(1,0,0,0,0,0,5), 32'd0,        32'h7FFFFFFF, 32'hFFFFFFFF, 32'h1,      2, 0, 32'h80000000, 32'd0, 32'd1, 32'h7FFFFFFF, 32'd0,    1'b0};
    vt[14] = '{1'b1, mk_ctrl(1,0,0,0,0,0,4), 32'd6,        32'd6,        32'd0,        32'd0,      0, 0, 32'd0,  32'd0, 32'd0,        32'd6,        32'd0,       1'b0};

    // Reset values, asserted from time 0.
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Directed table: E-stage outputs after one edge, EX/MEM outputs after the second.
    for (int i = 0; i < 15; i++) begin
      valid_d = vt[i].valid; ctrl_d = vt[i].ctrl;
      rd1_d = vt[i].rd1; rd2_d = vt[i].rd2; imm_d = vt[i].imm; pc_d = vt[i].pc;
      pc4_d = vt[i].pc + 32'd4;
      rs1_d = 5'(i + 2); rs2_d = 5'(i + 3); rd_d = 5'(i + 1);
      fwd_a = vt[i].fa; fwd_b = vt[i].fb; am = vt[i].am; rw = vt[i].rw;
      @(posedge clk); #1;
      idle_d();
      chk($sformatf("vec%0d pcsrc", i), 32'(pcsrc_e), 32'(vt[i].exp_pcsrc));
      chk($sformatf("vec%0d target", i), tgt_e, vt[i].exp_tgt);
      chk($sformatf("vec%0d rs1_e", i), 32'(rs1_e), 32'(i + 2));
      @(posedge clk); #1;
      chk($sformatf("vec%0d alures", i), alures_m, vt[i].exp_res);
      chk($sformatf("vec%0d wdata", i), wdata_m, vt[i].exp_wd);
      chk($sformatf("vec%0d valid_m", i), 32'(valid_m), 32'(vt[i].valid));
      chk($sformatf("vec%0d rd_m", i), 32'(rd_m), 32'(i + 1));
      chk($sformatf("vec%0d m_ctrl", i), {29'd0, regwrite_m, memwrite_m, rsrc_m[1]},
          {29'd0, vt[i].ctrl[9], vt[i].ctrl[6], vt[i].ctrl[8]});
      chk($sformatf("vec%0d pc4_m", i), pc4_m, vt[i].pc + 32'd4);
    end
    fwd_a = 2'd0; fwd_b = 2'd0;

    // Flush and stall together: flush wins, bubble reaches EX/MEM.
    valid_d = 1'b1; ctrl_d = mk_ctrl(1,0,1,1,0,0,0); rd_d = 5'd7; rs1_d = 5'd1;
    flush = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; stall = 1'b0; idle_d();
    chk("flushstall pcsrc", 32'(pcsrc_e), 32'd0);
    @(posedge clk); #1;
    chk("flushstall m_ctrl", {29'd0, valid_m, regwrite_m, memwrite_m}, 32'd0);

    // Stall for two edges: ID/EX holds, EX/MEM receives a copy on each stalled edge.
    valid_d = 1'b1; ctrl_d = mk_ctrl(1,0,0,0,0,0,0); rd1_d = 32'd1; rd2_d = 32'd2;
    rs1_d = 5'd7; rs2_d = 5'd8; rd_d = 5'd9;
    @(posedge clk); #1;
    chk("stall load rs1_e", 32'(rs1_e), 32'd7);
    stall = 1'b1; rs1_d = 5'd12; rd_d = 5'd4; rd1_d = 32'd50;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d rs1_e", k), 32'(rs1_e), 32'd7);
      chk($sformatf("stall%0d rd_e", k), 32'(rd_e), 32'd9);
      chk($sformatf("stall%0d dup valid_m", k), 32'(valid_m), 32'd1);
      chk($sformatf("stall%0d dup rd_m", k), 32'(rd_m), 32'd9);
      chk($sformatf("stall%0d dup alures", k), alures_m, 32'd3);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    chk("unstall rs1_e", 32'(rs1_e), 32'd12);

    // Asynchronous reset mid-stream with a taken jump sitting in E.
    valid_d = 1'b1; ctrl_d = mk_ctrl(1,0,1,1,0,0,0); pc_d = 32'h80; imm_d = 32'd4;
    rs1_d = 5'd3; rd_d = 5'd5; pc4_d = 32'h84;
    @(posedge clk); #1;
    chk("prereset pcsrc", 32'(pcsrc_e), 32'd1);
    @(posedge clk); #1;
    chk("prereset valid_m", 32'(valid_m), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(posedge clk); #1;
    chk_all_zero("heldreset");
    valid_d = 1'b1; ctrl_d = mk_ctrl(1,0,0,0,0,0,0); rs1_d = 5'd21; rd_d = 5'd22;
    rd1_d = 32'd1; rd2_d = 32'd1; pc4_d = 32'd4; imm_d = 32'd0; pc_d = 32'd0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postreset rs1_e", 32'(rs1_e), 32'd21);
    chk("postreset rd_e", 32'(rd_e), 32'd22);
    e = snap_d();

    // Random stream against the model.
    for (int n = 0; n < 400; n++) begin
      valid_d = ($urandom_range(0, 3) != 0);
      ctrl_d  = 10'($urandom);
      if (!valid_d) begin
        ctrl_d[9] = 1'b0; ctrl_d[6] = 1'b0; ctrl_d[5] = 1'b0; ctrl_d[4] = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        rd1_d = 32'($urandom_range(0, 3)); rd2_d = 32'($urandom_range(0, 3));
      end else begin
        rd1_d = $urandom; rd2_d = $urandom;
      end
      imm_d = $urandom; pc_d = $urandom; pc4_d = pc_d + 32'd4;
      rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
      fwd_a = 2'($urandom); fwd_b = 2'($urandom);
      am = 32'($urandom_range(0, 3)); rw = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 7) == 0);
      d = snap_d();
      #1;
      cur = exec(e, fwd_a, fwd_b, am, rw);
      chk($sformatf("rnd%0d pcsrc", n), 32'(pcsrc_e), 32'(ref_pcsrc(e, cur)));
      if (e.valid) begin
        chk($sformatf("rnd%0d target", n), tgt_e, e.pc + e.imm);
        chk($sformatf("rnd%0d e_idx", n), {17'd0, rs1_e, rs2_e, rd_e}, {17'd0, e.rs1, e.rs2, e.rd});
        chk($sformatf("rnd%0d rsrc0_e", n), 32'(rsrc0_e), 32'(e.ctrl[7]));
      end
      mexp = cur;
      @(posedge clk); #1;
      if (flush) begin
        e.valid = 1'b0;
        e.ctrl[9] = 1'b0; e.ctrl[6] = 1'b0; e.ctrl[5] = 1'b0; e.ctrl[4] = 1'b0;
      end else if (!stall) begin
        e = d;
      end
      chk($sformatf("rnd%0d m_ctrl", n), {29'd0, valid_m, regwrite_m, memwrite_m},
          {29'd0, mexp.valid, mexp.regw, mexp.memw});
      if (mexp.valid) begin
        chk($sformatf("rnd%0d alures", n), alures_m, mexp.res);
        chk($sformatf("rnd%0d wdata", n), wdata_m, mexp.wd);
        chk($sformatf("rnd%0d pc4_m", n), pc4_m, mexp.pc4);
        chk($sformatf("rnd%0d rd_rsrc_m", n), {25'd0, rsrc_m, rd_m}, {25'd0, mexp.rsrc, mexp.rd});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the pipelined RV32I core.
- Holds the ID/EX pipeline register, which captures the decode-stage control word, including the 3-bit ALU control from the ALU decoder.
- Applies operand forwarding, evaluates the ALU and the branch/jump decision, and registers the result into the EX/MEM pipeline register.
- Consumes decode outputs and feeds the memory stage and the hazard unit.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register index width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_flush_e  in  1  load-use/branch flush: bubble into ID/EX
i_stall_e  in  1  hold ID/EX contents
i_valid_d  in  1  decode slot holds a real instruction
i_ctrl_d  in  10  {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, ALUControl[2:0]}
i_rd1_d, i_rd2_d, i_imm_d, i_pc_d, i_pcplus4_d  in  XLEN  decode operands
i_rs1_d, i_rs2_d, i_rd_d  in  REG_AW  register indices
i_fwd_a_e, i_fwd_b_e  in  2  forward select from hazard unit
i_alures_m  in  XLEN  forwarded EX/MEM ALU result
i_result_w  in  XLEN  forwarded writeback result
o_rs1_e, o_rs2_e, o_rd_e  out  REG_AW  E-stage indices to hazard unit
o_resultsrc0_e  out  1  E-stage load indicator to hazard unit
o_pcsrc_e  out  1  redirect fetch
o_pctarget_e  out  XLEN  branch/jump target
o_valid_m, o_regwrite_m, o_memwrite_m  out  1  EX/MEM control
o_resultsrc_m  out  2  EX/MEM result select
o_alures_m, o_writedata_m, o_pcplus4_m  out  XLEN  EX/MEM data
o_rd_m  out  REG_AW  EX/MEM destination

Behaviour:
- Reset (asynchronous, i_rst_n low): all ID/EX and EX/MEM registers clear to 0. Every output is therefore 0 during reset, including o_pcsrc_e.
- ID/EX update priority per rising edge:
  - i_flush_e: load a bubble. valid, RegWrite, MemWrite, Jump and Branch = 0. Data fields may hold any value.
  - else i_stall_e: hold all contents.
  - else: capture the D inputs.
- Flush has priority over stall when both are asserted.
- Forwarding mux, per operand:
  - 00: ID/EX register value
  - 01: i_result_w
  - 10: i_alures_m
  - 11: treated as 00
- SrcA = forwarded A.
- SrcB = ALUSrc ? imm : forwarded B.
- WriteData = forwarded B.
- ALU (combinational, same cycle), by ALUControl:
  - 000: ADD
  - 001: SUB
  - 010: AND
  - 011: OR
  - 101: SLT, signed, zero-extended 1-bit result
  - any other code: result 0
- Arithmetic wraps modulo 2^XLEN. No overflow flag.
- Zero = (ALU result == 0).
- o_pcsrc_e = valid_e & (Jump_e | (Branch_e & Zero)). This is combinational from the ID/EX register and forwarded data, so it is visible in the cycle the instruction is in E.
- o_pctarget_e = pc_e + imm_e (wraps).
- EX/MEM register advances every cycle and never stalls.
- Latency: decode inputs to EX/MEM outputs is 2 edges with no stall. Each cycle of i_stall_e adds 1.
- If i_stall_e is held while the instruction in E is valid, a copy of it enters EX/MEM on every stalled edge.
  - The hazard unit must therefore only assert i_stall_e together with a downstream bubble.
  - ex_stage does not suppress duplicates; the bench checks the raw behaviour.
- Reset mid-operation discards in-flight instructions. The first edge after deassertion captures D normally.

Decomposition:
- Shared package pipeline_pkg holds:
  - the ALU-control enum (ADD 000, SUB 001, AND 010, OR 011, SLT 101), reused by the ALU decoder
  - the forward-select enum (FWD_REG, FWD_WB, FWD_MEM)
  - the packed control-word struct matching i_ctrl_d field order
- One natural sub-module: alu (SrcA, SrcB, ALUControl -> result, zero), purely combinational.
- Pipeline registers and muxes stay in ex_stage.

Test Plan:
- ADD, no forwarding: rd1=5, rd2=7, ALUControl=000, ALUSrc=0, rd=3, valid=1 -> after 2 edges o_alures_m=12, o_rd_m=3, o_valid_m=1.
- SLT signed plus SUB wrap:
  - rd1=0xFFFFFFFF, rd2=1, ALUControl=101 -> o_alures_m=1.
  - SUB 0-1 -> 0xFFFFFFFF.
- Forwarding: i_fwd_a_e=10 with i_alures_m=100, i_fwd_b_e=01 with i_result_w=20, ALUControl=001 -> result 80. Select 11 behaves as 00.
- Branch taken: Branch=1, rd1=rd2=9, ALUControl=001, pc=0x40, imm=0x10 -> o_pcsrc_e=1, o_pctarget_e=0x50 in E cycle. Same stimulus with valid=0 -> o_pcsrc_e=0.
- Flush and stall together for one edge with a valid RegWrite instruction in D -> next cycle o_pcsrc_e=0, and one edge later o_valid_m=0, o_regwrite_m=0, o_memwrite_m=0.
- Stall alone for 2 edges -> ID/EX value unchanged and o_rs1_e stable. Assert i_rst_n low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
